// File: rtl/serial_neg_pkg.sv
// serial_neg_pkg: shared types and helpers for the multi-lane bit-serial negator.
`default_nettype none

package serial_neg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_NEG  = 1'b1;

  // Bit-position counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_neg_lane.sv
// serial_neg_lane: one LSB-first two's-complement lane driven by shared frame strobes.
// Overflow tracking is compiled in when SERIAL_NEG_OVF_EN is defined.
`default_nettype none

module serial_neg_lane
  import serial_neg_pkg::*;
(
  input  logic clk,
  input  logic r,
  input  logic beat,
  input  logic first,
  input  logic b,
  input  logic neg,
  output logic y
`ifdef SERIAL_NEG_OVF_EN
  ,
  input  logic last,
  output logic ovf
`endif
);

  logic mode;
  logic seen;
  logic mode_eff;
  logic seen_eff;
  logic flip;

  // On the first bit the incoming mode applies immediately and history is cleared.
  assign mode_eff = first ? neg : mode;
  assign seen_eff = first ? 1'b0 : seen;
  assign flip     = (mode_eff == MODE_NEG) && seen_eff;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      mode <= MODE_PASS;
      seen <= 1'b0;
      y    <= 1'b0;
    end else if (beat) begin
      mode <= mode_eff;
      seen <= seen_eff | b;
      y    <= b ^ flip;
    end
  end

`ifdef SERIAL_NEG_OVF_EN
  logic zero;
  logic zero_eff;

  // zero: every bit of the current word seen so far was 0.
  assign zero_eff = first ? 1'b1 : zero;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      ovf <= last && (mode_eff == MODE_NEG) && b && zero_eff;
      if (beat) begin
        zero <= zero_eff & ~b;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/serial_negate_mc.sv
// serial_negate_mc: C-lane bit-serial pass/negate unit with shared word-frame controller.
// Define SERIAL_NEG_OVF_EN to add the per-lane ovf output.
`default_nettype none

module serial_negate_mc
  import serial_neg_pkg::*;
#(
  parameter int W = 8,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         r,
  input  logic         in_valid,
  input  logic         start,
  input  logic [C-1:0] i,
  input  logic [C-1:0] neg,
  output logic         out_valid,
  output logic         out_last,
  output logic [C-1:0] y,
  output logic         frame_err
`ifdef SERIAL_NEG_OVF_EN
  ,
  output logic [C-1:0] ovf
`endif
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          beat;
  logic          first;
  logic          last;
  logic          early;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    beat    = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    early   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && start) begin
          beat    = 1'b1;
          first   = 1'b1;
          state_n = ST_RUN;
          cnt_n   = CW'(1);
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          beat = 1'b1;
          if (start) begin
            // Early start: abandon the current word and restart at bit 0.
            first = 1'b1;
            early = 1'b1;
            cnt_n = CW'(1);
          end else if (cnt == CNT_LAST) begin
            last    = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out_valid <= beat;
      out_last  <= last;
      frame_err <= early;
    end
  end

  for (genvar k = 0; k < C; k++) begin : g_lane
    serial_neg_lane u_lane (
      .clk   (clk),
      .r     (r),
      .beat  (beat),
      .first (first),
      .b     (i[k]),
      .neg   (neg[k]),
      .y     (y[k])
`ifdef SERIAL_NEG_OVF_EN
      ,
      .last  (last),
      .ovf   (ovf[k])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_negate_mc.sv
// tb_serial_negate_mc: directed scoreboard bench for serial_negate_mc with W=8, C=2.
`default_nettype none

module tb_serial_negate_mc;

  logic       clk;
  logic       r;
  logic       in_valid;
  logic       start;
  logic [1:0] i;
  logic [1:0] neg;
  logic       out_valid;
  logic       out_last;
  logic [1:0] y;
  logic       frame_err;
`ifdef SERIAL_NEG_OVF_EN
  logic [1:0] ovf;
`endif

  typedef struct packed {
    logic [1:0] y;
    logic       last;
    logic       fe;
    logic [1:0] ov;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks   = 0;
  int   failures = 0;
  int   nvalid   = 0;
  int   fe_cnt   = 0;

  serial_negate_mc #(.W(8), .C(2)) dut (
    .clk       (clk),
    .r         (r),
    .in_valid  (in_valid),
    .start     (start),
    .i         (i),
    .neg       (neg),
    .out_valid (out_valid),
    .out_last  (out_last),
    .y         (y),
    .frame_err (frame_err)
`ifdef SERIAL_NEG_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: every valid beat must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!r) begin
      if (frame_err) fe_cnt++;
      if (out_valid) begin
        nvalid++;
        checks++;
        assert (q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_beat: observed y=%b with empty scoreboard, required no valid beat", y);
        end
        if (q.size() > 0) begin
          me = q.pop_front();
          checks++;
          assert (y === me.y) else begin
            failures++;
            $error("FAIL y: observed=%b required=%b", y, me.y);
          end
          checks++;
          assert (out_last === me.last) else begin
            failures++;
            $error("FAIL out_last: observed=%b required=%b", out_last, me.last);
          end
          checks++;
          assert (frame_err === me.fe) else begin
            failures++;
            $error("FAIL frame_err: observed=%b required=%b", frame_err, me.fe);
          end
`ifdef SERIAL_NEG_OVF_EN
          checks++;
          assert (ovf === me.ov) else begin
            failures++;
            $error("FAIL ovf: observed=%b required=%b", ovf, me.ov);
          end
`endif
        end
      end else begin
        checks++;
        assert (out_last === 1'b0 && frame_err === 1'b0) else begin
          failures++;
          $error("FAIL idle_strobes: observed last=%b fe=%b required 0/0", out_last, frame_err);
        end
      end
    end
  end

  function automatic logic [7:0] model(input logic [7:0] x, input logic n);
    return n ? (~x + 8'd1) : x;
  endfunction

  task automatic drive(input logic v, input logic st, input logic [1:0] ib, input logic [1:0] nb);
    @(posedge clk);
    #1;
    in_valid = v;
    start    = st;
    i        = ib;
    neg      = nb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'($urandom), 2'($urandom));
  endtask

  // Drives nbits of a word (LSB first) and queues the word-level expected result bits.
  task automatic word(input logic [7:0] x0, input logic [7:0] x1, input logic n0, input logic n1,
                      input int nbits, input int gap_at, input int gap_len, input bit fe0);
    logic [7:0] r0;
    logic [7:0] r1;
    exp_t       e;
    r0 = model(x0, n0);
    r1 = model(x1, n1);
    for (int k = 0; k < nbits; k++) begin
      if (k == gap_at) idle(gap_len);
      drive(1'b1, k == 0, {x1[k], x0[k]}, (k == 0) ? {n1, n0} : {~n1, ~n0});
      e.y    = {r1[k], r0[k]};
      e.last = (k == 7);
      e.fe   = fe0 && (k == 0);
      e.ov   = (k == 7) ? {n1 && (x1 == 8'h80), n0 && (x0 == 8'h80)} : 2'b00;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int beats_exp);
    idle(4);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL %s_drain: observed %0d pending beats, required 0", tag, q.size());
    end
    checks++;
    assert (nvalid == beats_exp) else begin
      failures++;
      $error("FAIL %s_beats: observed %0d valid beats, required %0d", tag, nvalid, beats_exp);
    end
    nvalid = 0;
  endtask

  initial begin
    r        = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    i        = 2'b00;
    neg      = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (out_valid === 1'b0 && out_last === 1'b0 && frame_err === 1'b0 && y === 2'b00) else begin
      failures++;
      $error("FAIL reset_state: observed v=%b l=%b fe=%b y=%b required all 0",
             out_valid, out_last, frame_err, y);
    end
    r = 1'b0;
    idle(2);
    nvalid = 0;

    // Lane0 negate 0x06 -> 0xFA, lane1 pass 0x35.
    word(8'h06, 8'h35, 1'b1, 1'b0, 8, -1, 0, 1'b0);
    drain("basic", 8);

    // Most-negative value negates to itself (overflow), zero stays zero.
    word(8'h80, 8'h00, 1'b1, 1'b1, 8, -1, 0, 1'b0);
    drain("min_neg", 8);

    // Stall of three cycles after bit 2: 0x5A negate -> 0xA6.
    word(8'h5A, 8'h5A, 1'b1, 1'b0, 8, 3, 3, 1'b0);
    drain("stall", 8);

    // Early start at bit 4, then a full word 0x01 negate -> 0xFF.
    fe_cnt = 0;
    word(8'h33, 8'h0C, 1'b1, 1'b1, 4, -1, 0, 1'b0);
    word(8'h01, 8'h01, 1'b1, 1'b0, 8, -1, 0, 1'b1);
    drain("early", 12);
    checks++;
    assert (fe_cnt == 1) else begin
      failures++;
      $error("FAIL frame_err_count: observed %0d pulses, required 1", fe_cnt);
    end

    // Reset at bit 3 discards the word.
    word(8'hC5, 8'h3A, 1'b1, 1'b0, 3, -1, 0, 1'b0);
    @(posedge clk);
    #1;
    r        = 1'b1;
    in_valid = 1'b1;
    i        = 2'b11;
    q.delete();
    #1;
    checks++;
    assert (out_valid === 1'b0 && out_last === 1'b0 && frame_err === 1'b0 && y === 2'b00) else begin
      failures++;
      $error("FAIL async_reset: observed v=%b l=%b fe=%b y=%b required all 0",
             out_valid, out_last, frame_err, y);
    end
    repeat (2) @(posedge clk);
    #1;
    r        = 1'b0;
    in_valid = 1'b0;
    nvalid   = 0;
    idle(1);
    repeat (3) drive(1'b1, 1'b0, 2'b11, 2'b11);
    word(8'h03, 8'hAA, 1'b1, 1'b1, 8, -1, 0, 1'b0);
    drain("post_reset", 8);

    // Back-to-back words: 0x01 pass then 0x7F negate -> 0x81.
    word(8'h01, 8'h3C, 1'b0, 1'b1, 8, -1, 0, 1'b0);
    word(8'h7F, 8'h80, 1'b1, 1'b0, 8, -1, 0, 1'b0);
    drain("b2b", 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
